// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, default FIFO depth, FIFO control states.
// Reused by the RX FIFO and, later, the TX FIFO.
package uart_pkg;

  localparam int UART_WORD_W     = 10;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    FULL_ST = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Only the read register is reset; the array contents are not.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver, with overrun flag and CPU interrupt.
// Define UART_RX_FIFO_THRESH_EN to raise IRQ_FIFO at a programmable level.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_WORD_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_CPU,
  input  logic             RST,
  input  logic             EN,
  input  logic             IRQ_Rx,
  input  logic [WIDTH-1:0] DATA_IN_Rx,
  input  logic             RD_EN,
  input  logic             CLR_OVR,
  input  logic [CW-1:0]    THRESH,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             EMPTY,
  output logic             FULL,
  output logic [CW-1:0]    COUNT,
  output logic             OVERRUN,
  output logic             IRQ_FIFO
);

  localparam int AW = $clog2(DEPTH);

  fifo_state_t   state, state_nxt;
  logic          irq_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          wr_req, wr_ok, rd_ok;
  logic          empty_nxt, full_nxt;
  logic          irq_nxt;

  assign wr_req = IRQ_Rx & ~irq_d & EN;
  assign rd_ok  = RD_EN & EN & ~EMPTY;
  assign wr_ok  = wr_req & (~FULL | rd_ok);
  assign COUNT  = count;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk_CPU),
    .rst     (RST),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (DATA_IN_Rx),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (DATA_OUT)
  );

  // Edge detector keeps tracking IRQ_Rx even while disabled.
  always_ff @(posedge clk_CPU) begin
    if (RST) irq_d <= 1'b0;
    else     irq_d <= IRQ_Rx;
  end

  // Occupancy change from accepted writes and reads.
  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy, read strobe and sticky overrun.
  always_ff @(posedge clk_CPU) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      DATA_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      DATA_VALID <= rd_ok;
      if (wr_req & ~wr_ok)   OVERRUN <= 1'b1;
      else if (CLR_OVR & EN) OVERRUN <= 1'b0;
    end
  end

  // Control state follows the next occupancy; flags decoded ahead of the register.
  always_comb begin
    state_nxt = state;
    if (count_nxt == '0)             state_nxt = IDLE;
    else if (count_nxt == CW'(DEPTH)) state_nxt = FULL_ST;
    else                              state_nxt = ACTIVE;
    empty_nxt = (state_nxt == IDLE);
    full_nxt  = (state_nxt == FULL_ST);
  end

  // State register with EMPTY/FULL as direct register outputs.
  always_ff @(posedge clk_CPU) begin
    if (RST) begin
      state <= IDLE;
      EMPTY <= 1'b1;
      FULL  <= 1'b0;
    end else begin
      state <= state_nxt;
      EMPTY <= empty_nxt;
      FULL  <= full_nxt;
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic [CW-1:0] thr;

  // Zero means one; anything past DEPTH means DEPTH.
  always_comb begin
    thr = THRESH;
    if (THRESH == '0)               thr = CW'(1);
    else if (THRESH > CW'(DEPTH))   thr = CW'(DEPTH);
    irq_nxt = (count >= thr) | OVERRUN;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;

  // Interrupt whenever anything is buffered or a word was lost.
  always_comb begin
    irq_nxt = ~EMPTY | OVERRUN;
  end
`endif

  // Interrupt registered one cycle behind the occupancy.
  always_ff @(posedge clk_CPU) begin
    if (RST) IRQ_FIFO <= 1'b0;
    else     IRQ_FIFO <= irq_nxt;
  end

endmodule
